fft16_twiddle_seq: RTL and testbench

- Twiddle-factor sequencer for the 16-point radix-2 DIF FFT datapath.
- Supplies the twiddle operand (in2_i/in2_q side) to the complex-conjugate multiplier, one twiddle per butterfly, in stage/butterfly order.
- Valid/ready handshake toward the multiplier-stage controller; optional inverse mode negates the sine term so the conj-multiplier performs the IFFT rotation.

---
 rtl/fft16_twiddle_seq_if.sv | 33 +++
 rtl/fft16_twiddle_seq.sv | 230 +++++++++++++++++++++++
 tb/tb_fft16_twiddle_seq.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fft16_twiddle_seq_if.sv
// Twiddle stream between fft16_twiddle_seq (master) and the multiplier stage (slave).
// Optional tw_trivial line exists only when TW_TRIVIAL_FLAG_EN is defined.
interface fft16_twiddle_seq_if #(
    parameter int TW_WORD_LENGTH = 5
);
    logic                             tw_valid;
    logic                             tw_ready;
    logic signed [TW_WORD_LENGTH-1:0] tw_i;
    logic signed [TW_WORD_LENGTH-1:0] tw_q;
    logic [2:0]                       tw_k;
    logic [1:0]                       stage;
    logic [2:0]                       bfly;
    logic                             tw_last;
`ifdef TW_TRIVIAL_FLAG_EN
    logic                             tw_trivial;
`endif

    modport master (
        output tw_valid, tw_i, tw_q, tw_k, stage, bfly, tw_last,
`ifdef TW_TRIVIAL_FLAG_EN
        output tw_trivial,
`endif
        input  tw_ready
    );

    modport slave (
        input  tw_valid, tw_i, tw_q, tw_k, stage, bfly, tw_last,
`ifdef TW_TRIVIAL_FLAG_EN
        input  tw_trivial,
`endif
        output tw_ready
    );
endinterface

// File: rtl/fft16_twiddle_seq.sv
// Twiddle-factor sequencer for a 16-point radix-2 DIF FFT: one twiddle per butterfly.
// Define TW_TRIVIAL_FLAG_EN to add the registered tw_trivial (k == 0) flag.
module fft16_twiddle_seq #(
    parameter int TW_WORD_LENGTH  = 5,
    parameter int TW_INT_LENGTH   = 0,
    parameter int TW_FLOAT_LENGTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic                 inverse,
    output logic                 busy,
    output logic                 done,
    fft16_twiddle_seq_if.master  tw
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int W  = TW_WORD_LENGTH;
    localparam int SH = 15 - TW_FLOAT_LENGTH;
    localparam logic signed [17:0] HALF = 18'sd1 <<< (SH - 1);
    localparam logic signed [17:0] MAXV = (18'sd1 <<< (TW_FLOAT_LENGTH + TW_INT_LENGTH)) - 18'sd1;
    localparam logic signed [17:0] MINV = -MAXV - 18'sd1;

    // S0.15 cosine ROM; +1.0 is saturated to 32767
    function automatic logic signed [15:0] rom_cos(input logic [2:0] k);
        logic signed [15:0] v;
        case (k)
            3'd0:    v = 16'sd32767;
            3'd1:    v = 16'sd30274;
            3'd2:    v = 16'sd23170;
            3'd3:    v = 16'sd12540;
            3'd4:    v = 16'sd0;
            3'd5:    v = -16'sd12540;
            3'd6:    v = -16'sd23170;
            default: v = -16'sd30274;
        endcase
        return v;
    endfunction

    function automatic logic signed [15:0] rom_sin(input logic [2:0] k);
        logic signed [15:0] v;
        case (k)
            3'd0:    v = 16'sd0;
            3'd1:    v = 16'sd12540;
            3'd2:    v = 16'sd23170;
            3'd3:    v = 16'sd30274;
            3'd4:    v = 16'sd32767;
            3'd5:    v = 16'sd30274;
            3'd6:    v = 16'sd23170;
            default: v = 16'sd12540;
        endcase
        return v;
    endfunction

    // Round half away from zero on the magnitude, then clamp to the output range
    function automatic logic signed [W-1:0] round_sat(input logic signed [15:0] v);
        logic signed [17:0] mag;
        logic signed [17:0] rnd;
        mag = v[15] ? -18'(v) : 18'(v);
        rnd = (mag + HALF) >>> SH;
        if (v[15]) begin
            rnd = -rnd;
        end
        if (rnd > MAXV) begin
            rnd = MAXV;
        end else if (rnd < MINV) begin
            rnd = MINV;
        end
        return W'(rnd);
    endfunction

    function automatic logic [2:0] k_of(input logic [1:0] s, input logic [2:0] b);
        logic [2:0] mask;
        case (s)
            2'd0:    mask = 3'd7;
            2'd1:    mask = 3'd3;
            2'd2:    mask = 3'd1;
            default: mask = 3'd0;
        endcase
        return (b & mask) << s;
    endfunction

    logic signed [W-1:0] cos_tab [8];
    logic signed [W-1:0] sin_tab [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_tab
            assign cos_tab[gi] = round_sat(rom_cos(3'(gi)));
            assign sin_tab[gi] = round_sat(rom_sin(3'(gi)));
        end
    endgenerate

    state_t              state_reg, state_next;
    logic [1:0]          stage_reg, stage_next;
    logic [2:0]          bfly_reg, bfly_next;
    logic [2:0]          k_reg, k_next;
    logic signed [W-1:0] i_reg, i_next;
    logic signed [W-1:0] q_reg, q_next;
    logic                valid_reg, valid_next;
    logic                last_reg, last_next;
    logic                inv_reg, inv_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                trivial_reg, trivial_next;
    logic                load;
    logic                clear;

    always_comb begin
        state_next   = state_reg;
        stage_next   = stage_reg;
        bfly_next    = bfly_reg;
        k_next       = k_reg;
        i_next       = i_reg;
        q_next       = q_reg;
        valid_next   = valid_reg;
        last_next    = last_reg;
        inv_next     = inv_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        trivial_next = trivial_reg;
        load         = 1'b0;
        clear        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    inv_next   = inverse;
                    stage_next = 2'd0;
                    bfly_next  = 3'd0;
                    valid_next = 1'b1;
                    busy_next  = 1'b1;
                    load       = 1'b1;
                end
            end
            RUN: begin
                if (valid_reg && tw.tw_ready) begin
                    if (last_reg) begin
                        state_next = DONE;
                        valid_next = 1'b0;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        clear      = 1'b1;
                    end else begin
                        {stage_next, bfly_next} = {stage_reg, bfly_reg} + 5'd1;
                        load = 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // The twiddle is looked up from the position it will hold next cycle
        if (load) begin
            k_next       = k_of(stage_next, bfly_next);
            i_next       = cos_tab[k_next];
            q_next       = inv_next ? -sin_tab[k_next] : sin_tab[k_next];
            last_next    = (stage_next == 2'd3) && (bfly_next == 3'd7);
            trivial_next = (k_next == 3'd0);
        end
        if (clear) begin
            stage_next   = 2'd0;
            bfly_next    = 3'd0;
            k_next       = 3'd0;
            i_next       = '0;
            q_next       = '0;
            last_next    = 1'b0;
            trivial_next = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg   <= IDLE;
            stage_reg   <= '0;
            bfly_reg    <= '0;
            k_reg       <= '0;
            i_reg       <= '0;
            q_reg       <= '0;
            valid_reg   <= 1'b0;
            last_reg    <= 1'b0;
            inv_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            trivial_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            stage_reg   <= stage_next;
            bfly_reg    <= bfly_next;
            k_reg       <= k_next;
            i_reg       <= i_next;
            q_reg       <= q_next;
            valid_reg   <= valid_next;
            last_reg    <= last_next;
            inv_reg     <= inv_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            trivial_reg <= trivial_next;
        end
    end

    assign tw.tw_valid = valid_reg;
    assign tw.tw_i     = i_reg;
    assign tw.tw_q     = q_reg;
    assign tw.tw_k     = k_reg;
    assign tw.stage    = stage_reg;
    assign tw.bfly     = bfly_reg;
    assign tw.tw_last  = last_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;

`ifdef TW_TRIVIAL_FLAG_EN
    assign tw.tw_trivial = trivial_reg;
`else
    logic unused_trivial;
    assign unused_trivial = trivial_reg;
`endif

endmodule

// File: tb/tb_fft16_twiddle_seq.sv
// Self-checking bench for fft16_twiddle_seq: real-arithmetic twiddle model plus literal pins.
module tb_fft16_twiddle_seq;
    localparam int  W  = 5;
    localparam int  F  = 4;
    localparam real PI = 3.14159265358979323846;

    logic CLK     = 1'b0;
    logic RST     = 1'b0;
    logic start   = 1'b0;
    logic inverse = 1'b0;
    logic busy;
    logic done;

    fft16_twiddle_seq_if #(.TW_WORD_LENGTH(W)) tw_bus();

    fft16_twiddle_seq #(
        .TW_WORD_LENGTH (W),
        .TW_INT_LENGTH  (0),
        .TW_FLOAT_LENGTH(F)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .start  (start),
        .inverse(inverse),
        .busy   (busy),
        .done   (done),
        .tw     (tw_bus)
    );

    always #5 CLK = ~CLK;

    int errors   = 0;
    int checks   = 0;
    int xfers    = 0;
    int dones    = 0;
    int trivials = 0;

    // Model state: frame in progress, transfer index, latched inverse
    bit m_active = 1'b0;
    bit m_done   = 1'b0;
    bit m_inv    = 1'b0;
    bit m_rst    = 1'b0;
    int m_n      = 0;
    int ei, eq, ek, es, eb;

    int lit_i [8] = '{15, 15, 11, 6, 0, -6, -11, -15};
    int lit_q [8] = '{0, 6, 11, 15, 15, 15, 11, 6};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rnd_sat(input real x);
        real y;
        int  r;
        y = x * real'(1 << F);
        if (y >= 0.0) r = $rtoi($floor(y + 0.5));
        else          r = -$rtoi($floor(-y + 0.5));
        if (r > (1 << F) - 1) r = (1 << F) - 1;
        if (r < -(1 << F))    r = -(1 << F);
        return r;
    endfunction

    function automatic void model_tw(input int n, input bit inv,
                                     output int i, output int q, output int k,
                                     output int s, output int b);
        s = n / 8;
        b = n % 8;
        k = (b % (8 >> s)) << s;
        i = rnd_sat($cos(2.0 * PI * real'(k) / 16.0));
        q = rnd_sat($sin(2.0 * PI * real'(k) / 16.0));
        if (inv) q = -q;
    endfunction

    // Compare against the model, then advance it with the inputs the next edge will see
    always @(negedge CLK) begin
        check("valid", int'(tw_bus.tw_valid), int'(m_active));
        check("busy", int'(busy), int'(m_active));
        check("done", int'(done), int'(m_done));
        if (m_active) begin
            model_tw(m_n, m_inv, ei, eq, ek, es, eb);
            check("tw_i", int'($signed(tw_bus.tw_i)), ei);
            check("tw_q", int'($signed(tw_bus.tw_q)), eq);
            check("tw_k", int'(tw_bus.tw_k), ek);
            check("stage", int'(tw_bus.stage), es);
            check("bfly", int'(tw_bus.bfly), eb);
            check("tw_last", int'(tw_bus.tw_last), int'(m_n == 31));
`ifdef TW_TRIVIAL_FLAG_EN
            check("tw_trivial", int'(tw_bus.tw_trivial), int'(ek == 0));
`endif
        end else begin
`ifdef TW_TRIVIAL_FLAG_EN
            check("trivial_idle", int'(tw_bus.tw_trivial), 0);
`endif
            if (m_rst) begin
                check("rst_tw_i", int'($signed(tw_bus.tw_i)), 0);
                check("rst_tw_q", int'($signed(tw_bus.tw_q)), 0);
                check("rst_tw_k", int'(tw_bus.tw_k), 0);
                check("rst_stage", int'(tw_bus.stage), 0);
                check("rst_bfly", int'(tw_bus.bfly), 0);
                check("rst_last", int'(tw_bus.tw_last), 0);
            end
        end

        if (RST && tw_bus.tw_valid && tw_bus.tw_ready) begin
            $display("xfer %0d: s=%0d b=%0d k=%0d i=%0d q=%0d last=%0d", xfers,
                     tw_bus.stage, tw_bus.bfly, tw_bus.tw_k, $signed(tw_bus.tw_i),
                     $signed(tw_bus.tw_q), tw_bus.tw_last);
            xfers++;
`ifdef TW_TRIVIAL_FLAG_EN
            if (tw_bus.tw_trivial) trivials++;
`endif
        end
        if (done) dones++;

        if (!RST) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_inv    = 1'b0;
            m_n      = 0;
            m_rst    = 1'b1;
        end else begin
            m_rst = 1'b0;
            if (m_active && tw_bus.tw_ready) begin
                m_done = (m_n == 31);
                if (m_n == 31) m_active = 1'b0;
                else           m_n++;
            end else begin
                if (!m_active && !m_done && start) begin
                    m_active = 1'b1;
                    m_n      = 0;
                    m_inv    = inverse;
                end
                m_done = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_done(input int bound, input bit rnd);
        for (int c = 0; c < bound; c++) begin
            if (rnd) tw_bus.tw_ready = 1'($urandom_range(0, 1));
            step();
            if (done) break;
        end
        check("done_seen", int'(done), 1);
        tw_bus.tw_ready = 1'b1;
    endtask

    initial begin
        tw_bus.tw_ready = 1'b0;
        RST = 1'b0;
        repeat (2) step();
        RST = 1'b1;
        tw_bus.tw_ready = 1'b1;

        // Frame A: forward, constant ready, a stray start mid-frame
        step();
        start = 1'b1;
        inverse = 1'b0;
        step();
        start = 1'b0;
        for (int j = 0; j < 8; j++) begin
            check("pin_i", int'($signed(tw_bus.tw_i)), lit_i[j]);
            check("pin_q", int'($signed(tw_bus.tw_q)), lit_q[j]);
            start = (j == 3);
            step();
        end
        start = 1'b0;
        wait_done(100, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("idle_after_done", int'(tw_bus.tw_valid), 0);

        // Frame B: inverse, started the first cycle back in IDLE, inverse toggled mid-frame
        start = 1'b1;
        inverse = 1'b1;
        step();
        start = 1'b0;
        inverse = 1'b0;
        check("inv_k0_i", int'($signed(tw_bus.tw_i)), 15);
        check("inv_k0_q", int'($signed(tw_bus.tw_q)), 0);
        step();
        step();
        check("inv_k2_i", int'($signed(tw_bus.tw_i)), 11);
        check("inv_k2_q", int'($signed(tw_bus.tw_q)), -11);
        inverse = 1'b1;
        step();
        inverse = 1'b0;
        wait_done(100, 1'b0);

        // Frame C: random back-pressure
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(600, 1'b1);

        // Frame D: reset while transfer 13 (s=1, b=5) is offered, then restart
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (13) step();
        check("pre_rst_stage", int'(tw_bus.stage), 1);
        check("pre_rst_bfly", int'(tw_bus.bfly), 5);
        RST = 1'b0;
        step();
        RST = 1'b1;
        check("post_rst_valid", int'(tw_bus.tw_valid), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_stage", int'(tw_bus.stage), 0);
        check("restart_bfly", int'(tw_bus.bfly), 0);
        wait_done(100, 1'b0);
        repeat (3) step();

        check("total_xfers", xfers, 4 * 32 + 13);
        check("total_dones", dones, 4);
`ifdef TW_TRIVIAL_FLAG_EN
        check("total_trivial", trivials, 4 * 15 + 3);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
